iterative_muldiv_unit: RTL and testbench
========================================

// Module: iterative_muldiv_unit
// PURPOSE
//  Multi-cycle unsigned multiply/divide unit directly downstream of the register file.
//  Consumes the A/B read-port operands plus destination address and iterates one bit per cycle.
//  Produces a single-cycle write-back request (wr_en/wr_addr/result) feeding the register file write port.
//  Keeps long-latency arithmetic off the single-cycle ALU path; the core stalls while busy is high.
// PARAMETERS
//  WIDTH    32  operand/result width; a_data, b_data and result are all WIDTH bits
//  CNT_W    5   iteration counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst       in   1      reset, synchronous, active-high
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00 MUL (low WIDTH bits), 01 MULHU (high WIDTH bits), 10 DIVU, 11 REMU
//  a_data    in   WIDTH  operand A (multiplicand / dividend)
//  b_data    in   WIDTH  operand B (multiplier / divisor)
//  d_addr    in   5      destination register for the result
//  busy      out  1      high in RUN and DONE; core must hold start low and stall
//  done      out  1      one-cycle pulse; result is valid in that cycle
//  wr_en     out  1      write-back enable to register file; equals done
//  wr_addr   out  5      latched d_addr of the accepted request
//  result    out  WIDTH  final value; held until the next completion
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, wr_en = 0; wr_addr = 0; result = 0; counter and datapath regs = 0.
//   rst has priority over every other input; asserting it mid-RUN aborts the op with no write-back.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: if start=1, latch a_data, b_data, op, d_addr; counter=0.
//    If op is DIVU/REMU and b_data=0 -> go DONE directly (fast path), else -> RUN.
//    If start=0, stay in IDLE.
//   RUN: one iteration per cycle; counter increments by 1; after the step with counter==WIDTH-1 -> DONE.
//   DONE: done=wr_en=1 for exactly this cycle; -> IDLE unconditionally.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH+1 (33 cycles for WIDTH=32).
//   Divide-by-zero fast path: done high in the cycle after edge k+1.
//  MUL/MULHU: radix-2 shift-add; 2*WIDTH-bit product {hi,lo}; MUL returns lo, MULHU returns hi.
//  DIVU/REMU: restoring division; the remainder register is WIDTH+1 bits so the subtract borrow is not lost.
//   DIVU returns the quotient; REMU returns the remainder.
//  Divide by zero: DIVU returns all ones ({WIDTH{1'b1}}); REMU returns the dividend a_data.
//  start while busy=1 is ignored; the in-flight op and its latched operands are unaffected.
//  start in the same cycle as done is also ignored; a new request is accepted only in the following IDLE cycle.
//  Operands are latched at accept; later changes on a_data/b_data/d_addr have no effect.
//  result/wr_addr update only at the DONE transition; between ops they hold the last completed values.
//  Back-to-back throughput: one op per WIDTH+2 cycles.
// TESTING
//  Reset, then MUL 7*6, d_addr=3: busy rises next cycle; done/wr_en pulse 33 cycles after start; result=42, wr_addr=3.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
//  DIVU 5/0 -> done after 1 cycle, result=0xFFFFFFFF; REMU 5/0 -> done after 1 cycle, result=5.
//  Second start pulsed during RUN with different operands -> ignored; first result correct; exactly one done pulse.
//  rst asserted 10 cycles into a MUL -> next cycle busy=0, result=0; no wr_en pulse; a fresh op then completes correctly.

Source files
------------

// File: rtl/iterative_muldiv_unit.sv
// ---------------------------------------------------------------------------
// iterative_muldiv_unit
//
// Multi-cycle unsigned multiply/divide unit that sits behind the register
// file read ports. It takes operands A/B and a destination address. It then
// iterates one bit per cycle. When it finishes it issues a single-cycle
// write-back request to the register file write port. The core stalls
// while busy is high.
//
// Parameters
//   WIDTH  operand/result width
//   CNT_W  iteration counter width (2**CNT_W >= WIDTH)
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request strobe, only honoured when idle
//   op       in   00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU
//   a_data   in   multiplicand / dividend
//   b_data   in   multiplier / divisor
//   d_addr   in   destination register of the request
//   busy     out  an operation is in flight (RUN or DONE)
//   done     out  one-cycle completion pulse, result valid with it
//   wr_en    out  register file write enable (same as done)
//   wr_addr  out  destination of the last completed operation
//   result   out  last completed result, held between operations
// ---------------------------------------------------------------------------
module iterative_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [4:0]       d_addr,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Datapath registers.
  //   hi_reg  : MUL -> upper product half (MSB stays 0)
  //             DIV -> partial remainder, one extra bit so the borrow of the
  //                    trial subtraction is never lost
  //   lo_reg  : MUL -> multiplier shifting out / product low half shifting in
  //             DIV -> dividend shifting out / quotient shifting in
  //   opnd_reg: MUL -> multiplicand, DIV -> divisor
  logic [WIDTH:0]   hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opnd_reg;
  logic [1:0]       op_reg;
  logic [4:0]       addr_reg;
  logic             dz_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] result_reg, result_next;
  logic [4:0]       wr_addr_reg;
  logic             done_reg;

  logic accept;
  logic div_zero;
  logic last_step;

  // The completion pulse is registered, so it is visible in the cycle after
  // the FSM leaves DONE. Blocking acceptance during that pulse means a start
  // that coincides with done is dropped. The next request is taken one
  // cycle later.
  assign accept    = (state_reg == S_IDLE) && start && !done_reg;
  assign div_zero  = op[1] && (b_data == '0);
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // One iteration step
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the whole {carry, hi, lo} right by one.
    mul_sum   = hi_reg + (lo_reg[0] ? {1'b0, opnd_reg} : '0);

    // Restoring division: bring the next dividend bit into the remainder
    // and try to subtract the divisor. A set top bit of the difference
    // means the subtraction borrowed, so the remainder is kept.
    div_shift = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};

    hi_next = hi_reg;
    lo_next = lo_reg;
    if (op_reg[1]) begin
      if (div_diff[WIDTH+1]) begin
        hi_next = div_shift;
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end else begin
        hi_next = div_diff[WIDTH:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_next = {1'b0, mul_sum[WIDTH:1]};
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Final value selection. The divide-by-zero results are fixed by the
  // architecture. The divide loop is skipped in that case, so the dividend
  // still sits untouched in lo_reg.
  always_comb begin
    result_next = lo_reg;
    case (op_reg)
      OP_MUL:   result_next = lo_reg;
      OP_MULHU: result_next = hi_reg[WIDTH-1:0];
      OP_DIVU:  result_next = dz_reg ? {WIDTH{1'b1}} : lo_reg;
      OP_REMU:  result_next = dz_reg ? lo_reg : hi_reg[WIDTH-1:0];
      default:  result_next = lo_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      op_reg      <= '0;
      addr_reg    <= '0;
      dz_reg      <= 1'b0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      wr_addr_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg   <= op;
            addr_reg <= d_addr;
            dz_reg   <= div_zero;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            if (op[1]) begin
              lo_reg   <= a_data;
              opnd_reg <= b_data;
            end else begin
              lo_reg   <= b_data;
              opnd_reg <= a_data;
            end
          end
        end
        S_RUN: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        S_DONE: begin
          result_reg  <= result_next;
          wr_addr_reg <= addr_reg;
          done_reg    <= 1'b1;
        end
        default: begin
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign done    = done_reg;
  assign wr_en   = done_reg;
  assign wr_addr = wr_addr_reg;
  assign result  = result_reg;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
module tb_iterative_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_data = '0;
  logic [W-1:0] b_data = '0;
  logic [4:0]   d_addr = '0;
  logic         busy, done, wr_en;
  logic [4:0]   wr_addr;
  logic [W-1:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  iterative_muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a_data  (a_data),
    .b_data  (b_data),
    .d_addr  (d_addr),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the architectural definition.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return prod[W-1:0];
      2'b01:   return prod[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. With inject set, a second
  // start carrying other operands is pulsed while the first op is running.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] ad, input bit inject);
    logic [W-1:0] exp_res;
    int lat_exp;
    int n;
    int extra;
    bit seen;
    exp_res = model(o, a, b);
    lat_exp = (o[1] && b == 0) ? 1 : W + 1;
    @(posedge clk); #1;
    start = 1'b1; op = o; a_data = a; b_data = b; d_addr = ad;
    @(posedge clk); #1;
    // Scramble the inputs: the unit must work from the latched copies.
    start = 1'b0; op = 2'($urandom); a_data = $urandom; b_data = $urandom | 1;
    d_addr = 5'($urandom);
    check(tag, "busy_after_accept", 64'(busy), 64'(1));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      if (inject && n == 4) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done) seen = 1'b1;
    end
    check(tag, "latency", 64'(n), 64'(lat_exp));
    check(tag, "result", 64'(result), 64'(exp_res));
    check(tag, "wr_addr", 64'(wr_addr), 64'(ad));
    check(tag, "wr_en", 64'(wr_en), 64'(1));
    // A start that coincides with the done pulse must be ignored.
    start = 1'b1; op = 2'b00; a_data = 32'd3; b_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check(tag, "start_at_done_ignored", 64'(busy), 64'(0));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wr_en) extra++;
    end
    check(tag, "no_extra_done", 64'(extra), 64'(0));
    check(tag, "result_held", 64'(result), 64'(exp_res));
  endtask

  initial begin
    int pulses;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "busy", 64'(busy), 64'(0));
    check("reset", "done", 64'(done), 64'(0));
    check("reset", "wr_en", 64'(wr_en), 64'(0));
    check("reset", "wr_addr", 64'(wr_addr), 64'(0));
    check("reset", "result", 64'(result), 64'(0));
    rst = 1'b0;

    do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 1'b0);
    do_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0);
    do_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd11, 1'b0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd12, 1'b0);
    do_op("divu_msb_1", 2'b10, 32'h8000_0000, 32'd1, 5'd13, 1'b0);
    do_op("divu_5_0", 2'b10, 32'd5, 32'd0, 5'd14, 1'b0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd15, 1'b0);
    do_op("mul_inject", 2'b00, 32'd1234, 32'd5678, 5'd21, 1'b1);
    do_op("divu_inject", 2'b10, 32'hDEAD_BEEF, 32'd17, 5'd22, 1'b1);

    // Reset ten cycles into a MUL: aborted, no write-back.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a_data = 32'd99; b_data = 32'd77; d_addr = 5'd30;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_run", "busy", 64'(busy), 64'(0));
    check("rst_mid_run", "result", 64'(result), 64'(0));
    check("rst_mid_run", "wr_addr", 64'(wr_addr), 64'(0));
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wr_en) pulses++;
    end
    check("rst_mid_run", "no_writeback", 64'(pulses), 64'(0));
    do_op("after_rst", 2'b00, 32'd99, 32'd77, 5'd30, 1'b0);

    // Random operations, with the occasional zero divisor.
    for (int t = 0; t < 16; t++) begin
      r_op = 2'($urandom);
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_op($sformatf("rand%0d_op%0d", t, r_op), r_op, r_a, r_b, 5'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
